dds_wave_gen: RTL

- Parametrised next-generation DDS core: phase accumulator, phase offset, quarter-wave sine ROM addressing, and runtime-selectable waveform (sine/square/sawtooth/triangle).
- Frequency/phase/mode updates are glitch-free: staged, then applied at a phase wrap.
- Drives a synchronous quarter-wave ROM (external instance) and produces a signed sample stream with wrap markers for downstream DAC/PWM blocks.

---
 rtl/dds_wave_gen.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator with glitch-free staged config,
// quarter-wave ROM addressing and a sine/square/sawtooth/triangle output stage.
module dds_wave_gen #(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned PHASE_W = 12,
  parameter int unsigned OUT_W   = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      sync_clr,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [ACC_W-1:0]          cfg_k,
  input  logic [PHASE_W-1:0]        cfg_p,
  input  logic [1:0]                cfg_mode,
  output logic [PHASE_W-3:0]        rom_addr,
  input  logic [OUT_W-2:0]          rom_data,
  output logic signed [OUT_W-1:0]   dout,
  output logic                      dout_valid,
  output logic                      wrap_pulse
);

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_SAW    = 2'd2,
    MODE_TRI    = 2'd3
  } mode_t;

  localparam logic [OUT_W-1:0] POS_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_MAX   = OUT_W'(0) - POS_MAX;
  localparam logic [OUT_W-1:0] SIGN_FLIP = {1'b1, {(OUT_W-1){1'b0}}};

  logic [ACC_W-1:0]   acc;
  logic               acc_wrap;
  logic [ACC_W-1:0]   k_act, k_pend;
  logic [PHASE_W-1:0] p_act, p_pend;
  mode_t              mode_act, mode_pend;

  logic [ACC_W:0]     sum_c;
  logic               carry_c;
  logic               apply_c;
  logic               xfer_c;

  logic [PHASE_W-1:0] phase_c;
  logic [PHASE_W-3:0] idx_c;

  logic [PHASE_W-1:0] s1_phase, s2_phase;
  mode_t              s1_mode, s2_mode;
  logic               s1_wrap, s2_wrap;
  logic [1:0]         vld_sr;

  logic [OUT_W-1:0]   mag_c;
  logic [PHASE_W-2:0] fold_c;
  logic [OUT_W-1:0]   sample_c;

  assign sum_c   = {1'b0, acc} + {1'b0, k_act};
  assign carry_c = sum_c[ACC_W];
  // Any carry (even one masked by sync_clr), a clear, or a pause lets staged config take over.
  assign apply_c = carry_c | sync_clr | ~en;
  assign xfer_c  = cfg_valid & cfg_ready;

  // Config handshake: capture into pending, promote to active on the next apply event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ready <= 1'b1;
      k_pend    <= '0;
      p_pend    <= '0;
      mode_pend <= MODE_SINE;
      k_act     <= '0;
      p_act     <= '0;
      mode_act  <= MODE_SINE;
    end else if (xfer_c) begin
      cfg_ready <= 1'b0;
      k_pend    <= cfg_k;
      p_pend    <= cfg_p;
      mode_pend <= mode_t'(cfg_mode);
    end else if (!cfg_ready && apply_c) begin
      cfg_ready <= 1'b1;
      k_act     <= k_pend;
      p_act     <= p_pend;
      mode_act  <= mode_pend;
    end
  end

  // Phase accumulator; the wrap flag travels with the first post-wrap value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      acc_wrap <= 1'b0;
    end else if (sync_clr) begin
      acc      <= '0;
      acc_wrap <= 1'b0;
    end else if (en) begin
      acc      <= sum_c[ACC_W-1:0];
      acc_wrap <= carry_c;
    end else begin
      acc_wrap <= 1'b0;
    end
  end

  assign phase_c = acc[ACC_W-1 -: PHASE_W] + p_act;
  assign idx_c   = phase_c[PHASE_W-3:0];

  // Stage 1: phase offset, quarter-wave address mirroring, sideband capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      s1_phase <= '0;
      s1_mode  <= MODE_SINE;
      s1_wrap  <= 1'b0;
    end else begin
      rom_addr <= phase_c[PHASE_W-2] ? ~idx_c : idx_c;
      s1_phase <= phase_c;
      s1_mode  <= mode_act;
      s1_wrap  <= acc_wrap;
    end
  end

  // Stage 2: sideband waits out the ROM read cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_phase <= '0;
      s2_mode  <= MODE_SINE;
      s2_wrap  <= 1'b0;
    end else begin
      s2_phase <= s1_phase;
      s2_mode  <= s1_mode;
      s2_wrap  <= s1_wrap;
    end
  end

  // Waveform shaping from the delayed phase and ROM magnitude.
  always_comb begin
    sample_c = '0;
    mag_c    = {1'b0, rom_data};
    fold_c   = s2_phase[PHASE_W-1] ? ~s2_phase[PHASE_W-2:0] : s2_phase[PHASE_W-2:0];
    case (s2_mode)
      MODE_SINE:   sample_c = s2_phase[PHASE_W-1] ? (OUT_W'(0) - mag_c) : mag_c;
      MODE_SQUARE: sample_c = s2_phase[PHASE_W-1] ? NEG_MAX : POS_MAX;
      MODE_SAW:    sample_c = OUT_W'({s2_phase, OUT_W'(0)} >> PHASE_W) ^ SIGN_FLIP;
      MODE_TRI:    sample_c = OUT_W'({fold_c, (OUT_W+1)'(0)} >> PHASE_W) ^ SIGN_FLIP;
      default:     sample_c = '0;
    endcase
  end

  // Stage 3: registered sample, wrap marker and fill-status flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      wrap_pulse <= 1'b0;
      vld_sr     <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout       <= sample_c;
      wrap_pulse <= s2_wrap;
      vld_sr     <= {vld_sr[0], 1'b1};
      dout_valid <= vld_sr[1];
    end
  end

endmodule
